// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// switch_debouncer : 2-FF synchroniser and shared-tick debouncer for a switch
//                    bus, with registered rise/fall/changed strobes.
// Revision         : 1.0
// ============================================================================
module switch_debouncer #(
  parameter int WIDTH        = 16,
  parameter int CLK_DIV      = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] switch_db,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
  output logic             changed
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic             tick;

  assign tick = (pre_cnt_q == c_pre_last);

  always_comb begin
    sync1_d   = switch;
    sync2_d   = sync1_q;
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    db_d      = db_q;
    rise_d    = '0;
    fall_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      // A match at any edge discards progress; only ticks advance a mismatch.
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == c_cnt_last) begin
          cnt_d[i]  = '0;
          db_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pre_cnt_q <= '0;
      db_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pre_cnt_q <= pre_cnt_d;
      db_q      <= db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign switch_db   = db_q;
  assign switch_rise = rise_q;
  assign switch_fall = fall_q;
  assign changed     = changed_q;

endmodule
`default_nettype wire
